// File: rtl/bot_sysreg_hub.sv
// bot_sysreg_hub: system-register hub between NUM_BOTS Rojobot simulators and the
// application CPU. Each bot's register set is snapshotted on its update pulse,
// the bot is marked pending, and a round-robin interrupt with ack handshake tells
// the CPU which bot to service. The CPU reads the coherent snapshots and owns the
// per-bot motor control registers.
module bot_sysreg_hub #(
  parameter int NUM_BOTS = 4,
  parameter int DATA_W   = 8,
  parameter int BOT_W    = (NUM_BOTS > 1) ? $clog2(NUM_BOTS) : 1,
  parameter int ADDR_W   = BOT_W + 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BOTS*6*DATA_W-1:0]  bot_regs,
  input  logic [NUM_BOTS-1:0]           bot_upd,
  output logic [NUM_BOTS*DATA_W-1:0]    MotCtl_out,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic                          cpu_rd,
  input  logic                          cpu_wr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          irq,
  output logic [BOT_W-1:0]              irq_bot,
  input  logic                          irq_ack
);

  localparam int NUM_REGS = 6;
  localparam int OVR_W    = 8;

  localparam logic [2:0] REG_MOTCTL = 3'd0;
  localparam logic [2:0] REG_OVR    = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_GAP
  } irq_state_e;

  // Snapshot, pending and overrun state per bot
  logic [DATA_W-1:0] snap_q  [NUM_BOTS][NUM_REGS];
  logic [DATA_W-1:0] snap_d  [NUM_BOTS][NUM_REGS];
  logic [NUM_BOTS-1:0] pending_q, pending_d;
  logic [OVR_W-1:0]  ovr_q   [NUM_BOTS];
  logic [OVR_W-1:0]  ovr_d   [NUM_BOTS];
  logic [DATA_W-1:0] motctl_q[NUM_BOTS];
  logic [DATA_W-1:0] motctl_d[NUM_BOTS];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Interrupt FSM state
  irq_state_e        state_q, state_d;
  logic [BOT_W-1:0]  irq_bot_q, irq_bot_d;
  logic [BOT_W-1:0]  last_q, last_d;

  // CPU address decode
  logic [BOT_W-1:0]  cpu_bot;
  logic [2:0]        cpu_reg;
  logic              cpu_bot_ok;
  logic              ack;
  logic [NUM_BOTS-1:0] in_svc;

  assign cpu_bot    = cpu_addr[ADDR_W-1:3];
  assign cpu_reg    = cpu_addr[2:0];
  assign cpu_bot_ok = (int'(cpu_bot) < NUM_BOTS);
  // An ack only means something while the interrupt is actually raised.
  assign ack        = irq_ack && (state_q == ST_ASSERT);

  assign irq       = (state_q == ST_ASSERT);
  assign irq_bot   = irq_bot_q;
  assign cpu_rdata = rdata_q;

  // Which bot (if any) the CPU is currently servicing
  always_comb begin
    in_svc = '0;
    for (int b = 0; b < NUM_BOTS; b++) begin
      in_svc[b] = (state_q == ST_ASSERT) && (irq_bot_q == BOT_W'(b));
    end
  end

  // Flatten the motor control registers onto the output bus
  always_comb begin
    MotCtl_out = '0;
    for (int b = 0; b < NUM_BOTS; b++) begin
      MotCtl_out[b*DATA_W +: DATA_W] = motctl_q[b];
    end
  end

  // Snapshot capture, pending set/clear and overrun counting
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    snap_d    = snap_q;
    pending_d = pending_q;
    ovr_d     = ovr_q;
    for (int b = 0; b < NUM_BOTS; b++) begin
      if (bot_upd[b]) begin
        if (in_svc[b] && !ack) begin
          // Bot under service: snapshot frozen, update lost.
          if (ovr_q[b] != '1) ovr_d[b] = ovr_q[b] + OVR_W'(1);
        end else begin
          for (int r = 0; r < NUM_REGS; r++) begin
            snap_d[b][r] = bot_regs[(b*NUM_REGS+r)*DATA_W +: DATA_W];
          end
          // Overwriting an unserviced snapshot counts as an overrun; re-arming
          // on the ack cycle does not.
          if (pending_q[b] && !in_svc[b] && (ovr_q[b] != '1)) begin
            ovr_d[b] = ovr_q[b] + OVR_W'(1);
          end
          pending_d[b] = 1'b1;
        end
      end else if (in_svc[b] && ack) begin
        pending_d[b] = 1'b0;
      end
      // CPU clear takes priority over a same-cycle increment.
      if (cpu_wr && cpu_bot_ok && (cpu_reg == REG_OVR) && (int'(cpu_bot) == b)) begin
        ovr_d[b] = '0;
      end
    end
  end

  // CPU writes to the motor control registers
  always_comb begin
    motctl_d = motctl_q;
    if (cpu_wr && cpu_bot_ok && (cpu_reg == REG_MOTCTL)) begin
      motctl_d[cpu_bot] = cpu_wdata;
    end
  end

  // CPU read mux; data is registered and held between reads
  always_comb begin
    rdata_d = rdata_q;
    if (cpu_rd) begin
      rdata_d = '0;
      if (cpu_bot_ok) begin
        case (cpu_reg)
          REG_OVR:    rdata_d = DATA_W'(ovr_q[cpu_bot]);
          REG_STATUS: rdata_d = {{(DATA_W-2){1'b0}}, in_svc[cpu_bot], pending_q[cpu_bot]};
          default:    rdata_d = snap_q[cpu_bot][cpu_reg];
        endcase
      end
    end
  end

  // Interrupt FSM next state: round-robin select, hold until ack, one idle gap
  always_comb begin
    logic             found;
    int               cand;
    logic [BOT_W-1:0] cand_idx;
    state_d   = state_q;
    irq_bot_d = irq_bot_q;
    last_d    = last_q;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    case (state_q)
      ST_IDLE: begin
        for (int i = 1; i <= NUM_BOTS; i++) begin
          cand     = (int'(last_q) + i) % NUM_BOTS;
          cand_idx = BOT_W'(cand);
          if (!found && pending_q[cand_idx]) begin
            found     = 1'b1;
            irq_bot_d = cand_idx;
          end
        end
        if (found) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (irq_ack) begin
          last_d  = irq_bot_q;
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      // NOTE: the snapshot array is small and architecturally visible, so it is reset like any other register.
      for (int b = 0; b < NUM_BOTS; b++) begin
        for (int r = 0; r < NUM_REGS; r++) snap_q[b][r] <= '0;
        ovr_q[b]    <= '0;
        motctl_q[b] <= '0;
      end
      pending_q <= '0;
      rdata_q   <= '0;
      state_q   <= ST_IDLE;
      irq_bot_q <= '0;
      last_q    <= BOT_W'(NUM_BOTS - 1);
    end else begin
      snap_q    <= snap_d;
      ovr_q     <= ovr_d;
      motctl_q  <= motctl_d;
      pending_q <= pending_d;
      rdata_q   <= rdata_d;
      state_q   <= state_d;
      irq_bot_q <= irq_bot_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_bot_sysreg_hub.sv
// Testbench for bot_sysreg_hub: directed stimulus pushes expected read data and
// expected interrupt order into queues; a monitor compares them as the DUT
// presents read data and raises irq.
module tb_bot_sysreg_hub;

  localparam int NUM_BOTS = 4;
  localparam int DATA_W   = 8;
  localparam int BOT_W    = 2;
  localparam int ADDR_W   = 5;

  logic                         clk;
  logic                         reset;
  logic [NUM_BOTS*6*DATA_W-1:0] bot_regs;
  logic [NUM_BOTS-1:0]          bot_upd;
  logic [NUM_BOTS*DATA_W-1:0]   MotCtl_out;
  logic [ADDR_W-1:0]            cpu_addr;
  logic                         cpu_rd;
  logic                         cpu_wr;
  logic [DATA_W-1:0]            cpu_wdata;
  logic [DATA_W-1:0]            cpu_rdata;
  logic                         irq;
  logic [BOT_W-1:0]             irq_bot;
  logic                         irq_ack;

  bot_sysreg_hub #(
    .NUM_BOTS(NUM_BOTS), .DATA_W(DATA_W), .BOT_W(BOT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .bot_regs(bot_regs), .bot_upd(bot_upd),
    .MotCtl_out(MotCtl_out), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .irq(irq), .irq_bot(irq_bot), .irq_ack(irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboards
  string      nm_q[$];
  logic [7:0] exp_q[$];
  int         irq_exp_q[$];

  logic rd_seen  = 1'b0;
  logic irq_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Remember which cycles carried a read strobe
  always @(posedge clk) rd_seen <= cpu_rd;

  // Monitor: compare read data and irq service order against the scoreboards
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got 0x%0h with no read expected", cpu_rdata);
      end else begin
        check(nm_q.pop_front(), {24'b0, cpu_rdata}, {24'b0, exp_q.pop_front()});
      end
    end
    if (irq && !irq_prev && !reset) begin
      if (irq_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL irq_unexpected: irq raised for bot %0d, none expected", irq_bot);
      end else begin
        check("irq_order", {30'b0, irq_bot}, irq_exp_q.pop_front());
      end
    end
    irq_prev <= irq;
  end

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic set_reg(input int b, input int r, input logic [7:0] v);
    bot_regs[(b*6+r)*8 +: 8] = v;
  endtask

  task automatic pulse(input logic [NUM_BOTS-1:0] m);
    bot_upd = m;
    cycle();
    bot_upd = '0;
  endtask

  task automatic rd(input int b, input int r, input logic [7:0] e, input string nm);
    nm_q.push_back(nm);
    exp_q.push_back(e);
    cpu_addr = ADDR_W'(b*8 + r);
    cpu_rd   = 1'b1;
    cycle();
    cpu_rd   = 1'b0;
  endtask

  task automatic wr(input int b, input int r, input logic [7:0] d);
    cpu_addr  = ADDR_W'(b*8 + r);
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    cycle();
    cpu_wr    = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
  endtask

  task automatic wait_irq(input string nm);
    int n = 0;
    while (!irq && n < 20) begin
      cycle();
      n++;
    end
    check(nm, {31'b0, irq}, 32'd1);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bot_regs  = '0;
    bot_upd   = '0;
    cpu_addr  = '0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_wdata = '0;
    irq_ack   = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Reset state
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_irq_bot", {30'b0, irq_bot}, 32'd0);
    check("rst_motctl", MotCtl_out, 32'd0);
    check("rst_rdata", {24'b0, cpu_rdata}, 32'd0);

    // Single update on bot 2: two-cycle irq latency, coherent snapshot
    set_reg(2, 0, 8'h12);
    set_reg(2, 1, 8'h34);
    irq_exp_q.push_back(2);
    pulse(4'b0100);
    set_reg(2, 0, 8'hEE);            // live value moves on; snapshot must not
    check("lat_irq_not_yet", {31'b0, irq}, 32'd0);
    cycle();
    check("lat_irq_high", {31'b0, irq}, 32'd1);
    check("lat_irq_bot", {30'b0, irq_bot}, 32'd2);
    rd(2, 0, 8'h12, "b2_locx");
    rd(2, 1, 8'h34, "b2_locy");
    rd(2, 7, 8'h03, "b2_status_svc");
    ack();
    check("gap_irq_low", {31'b0, irq}, 32'd0);
    rd(2, 7, 8'h00, "b2_status_clr");

    // Round robin from reset: all four, then 3 and 1 together
    reset_dut();
    for (int i = 0; i < 4; i++) irq_exp_q.push_back(i);
    pulse(4'b1111);
    repeat (4) begin
      wait_irq("rr_all_irq");
      ack();
    end
    irq_exp_q.push_back(1);
    irq_exp_q.push_back(3);
    pulse(4'b1010);
    repeat (2) begin
      wait_irq("rr_pair_irq");
      ack();
    end

    // Update during service is dropped; ack with update re-arms
    set_reg(1, 0, 8'h44);
    irq_exp_q.push_back(1);
    pulse(4'b0010);
    wait_irq("svc_irq");
    set_reg(1, 0, 8'h55);
    pulse(4'b0010);
    rd(1, 0, 8'h44, "b1_frozen");
    rd(1, 6, 8'h01, "b1_ovr_drop");
    set_reg(1, 0, 8'h66);
    irq_exp_q.push_back(1);
    irq_ack = 1'b1;
    bot_upd = 4'b0010;
    cycle();
    irq_ack = 1'b0;
    bot_upd = '0;
    check("ackupd_gap", {31'b0, irq}, 32'd0);
    wait_irq("ackupd_reirq");
    check("ackupd_bot", {30'b0, irq_bot}, 32'd1);
    rd(1, 0, 8'h66, "b1_reloaded");
    rd(1, 6, 8'h01, "b1_ovr_kept");
    rd(1, 7, 8'h03, "b1_status");
    ack();

    // Overrun counter saturates, clears, and clear beats increment
    irq_exp_q.push_back(3);
    bot_upd = 4'b1000;
    repeat (300) cycle();
    bot_upd = '0;
    check("sat_irq", {31'b0, irq}, 32'd1);
    rd(3, 6, 8'hFF, "b3_ovr_sat");
    wr(3, 6, 8'h5A);
    rd(3, 6, 8'h00, "b3_ovr_clr");
    pulse(4'b1000);
    rd(3, 6, 8'h01, "b3_ovr_inc");
    bot_upd   = 4'b1000;
    cpu_addr  = ADDR_W'(3*8 + 6);
    cpu_wr    = 1'b1;
    cycle();
    bot_upd   = '0;
    cpu_wr    = 1'b0;
    rd(3, 6, 8'h00, "b3_clr_wins");
    ack();

    // Motor control writes
    wr(0, 0, 8'h11);
    wr(1, 0, 8'hA5);
    check("motctl_wr", MotCtl_out, 32'h0000_A511);
    wr(2, 2, 8'hFF);
    check("motctl_ignored", MotCtl_out, 32'h0000_A511);
    rd(2, 0, 8'hEE, "b2_snap_untouched");

    // Asynchronous reset while irq is raised
    irq_exp_q.push_back(0);
    pulse(4'b0101);
    pulse(4'b0100);
    wait_irq("prerst_irq");
    rd(2, 6, 8'h01, "b2_ovr_prerst");
    #2 reset = 1'b1;
    #1;
    check("arst_irq", {31'b0, irq}, 32'd0);
    check("arst_irq_bot", {30'b0, irq_bot}, 32'd0);
    check("arst_motctl", MotCtl_out, 32'd0);
    check("arst_rdata", {24'b0, cpu_rdata}, 32'd0);
    cycle();
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("postrst_no_irq", {31'b0, irq}, 32'd0);
    end
    rd(0, 7, 8'h00, "b0_status_rst");
    rd(2, 6, 8'h00, "b2_ovr_rst");
    rd(1, 6, 8'h00, "b1_ovr_rst");
    rd(2, 0, 8'h00, "b2_snap_rst");
    irq_exp_q.push_back(0);
    pulse(4'b0001);
    wait_irq("postrst_irq");
    ack();
    cycle();
    cycle();

    check("rd_queue_drained", exp_q.size(), 32'd0);
    check("irq_queue_drained", irq_exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
